// File: rtl/pci_initiator.sv
// pci_initiator: bus-master agent for one PCI REQ#/GNT# slot.
// Requests the bus on a local start pulse and waits for grant plus an idle bus.
// It then runs one address phase and 1-15 data phases, with master abort and
// latency-timer preemption. Every output is a flop, so no input reaches an
// output combinationally.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | bus released, waiting for start with num_phases != 0
//   S_REQ_WAIT | REQ# low, waiting for GNT# low with FRAME#/IRDY# both high
//   S_ADDR     | address phase: FRAME# low, IRDY# high
//   S_DATA     | data phases: IRDY# low, FRAME# high on the last phase
//   S_ABORT    | master abort: FRAME# high, IRDY# low for one clock
//   S_TURN     | turnaround: both high, still driven, then release
module pci_initiator #(
  parameter int MAX_WAIT  = 8,
  parameter int LAT_TIMER = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_phases,
  input  logic       GNT,
  input  logic       GLOBAL_FRAME,
  input  logic       GLOBAL_IRDY,
  input  logic       GLOBAL_TRDY,
  output logic       REQ,
  output logic       FRAME_N,
  output logic       IRDY_N,
  output logic       BUS_OE,
  output logic       busy,
  output logic       data_ack,
  output logic [3:0] xfer_count,
  output logic       done,
  output logic       abort
);

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int LAT_W  = (LAT_TIMER > 1) ? $clog2(LAT_TIMER + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAX_WAIT - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LAT_TIMER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_WAIT,
    S_ADDR,
    S_DATA,
    S_ABORT,
    S_TURN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [3:0]        xfer_q, xfer_d;
  // Down-counters: the wait timer hits 0 on the last tolerated TRDY# miss.
  // The latency timer hits 0 once LAT_TIMER clocks have passed since ADDR entry.
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              abort_flag_q, abort_flag_d;
  logic              ack_d, done_d, abort_d;

  logic              req_q, frame_n_q, irdy_n_q, oe_q, busy_q;
  logic              ack_q, done_q, abort_q;

  // Next-state, counter and pulse computation
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    xfer_d       = xfer_q;
    wait_d       = wait_q;
    lat_d        = lat_q;
    abort_flag_d = abort_flag_q;
    ack_d        = 1'b0;
    done_d       = 1'b0;
    abort_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (num_phases != 4'd0)) begin
          rem_d        = num_phases;
          xfer_d       = 4'd0;
          abort_flag_d = 1'b0;
          state_d      = S_REQ_WAIT;
        end
      end
      S_REQ_WAIT: begin
        if (!GNT && GLOBAL_FRAME && GLOBAL_IRDY) begin
          lat_d   = LAT_LOAD;
          wait_d  = WAIT_LOAD;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        lat_d   = (lat_q == '0) ? '0 : lat_q - 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        lat_d = (lat_q == '0) ? '0 : lat_q - 1'b1;
        if (!GLOBAL_TRDY) begin
          ack_d  = 1'b1;
          xfer_d = xfer_q + 4'd1;
          rem_d  = rem_q - 4'd1;
          wait_d = WAIT_LOAD;
          if (rem_q == 4'd1) begin
            state_d = S_TURN;
          end
        end else if (wait_q == '0) begin
          abort_flag_d = 1'b1;
          state_d      = S_ABORT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
        // Preemption is applied after this edge's completion has been counted.
        if ((lat_q == '0) && GNT && (rem_d > 4'd1)) begin
          rem_d = 4'd1;
        end
      end
      S_ABORT: begin
        state_d = S_TURN;
      end
      S_TURN: begin
        done_d  = 1'b1;
        abort_d = abort_flag_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered bus/status outputs derived from next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rem_q        <= 4'd0;
      xfer_q       <= 4'd0;
      wait_q       <= '0;
      lat_q        <= '0;
      abort_flag_q <= 1'b0;
      req_q        <= 1'b1;
      frame_n_q    <= 1'b1;
      irdy_n_q     <= 1'b1;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      xfer_q       <= xfer_d;
      wait_q       <= wait_d;
      lat_q        <= lat_d;
      abort_flag_q <= abort_flag_d;
      req_q        <= (state_d != S_REQ_WAIT);
      frame_n_q    <= !((state_d == S_ADDR) ||
                        ((state_d == S_DATA) && (rem_d != 4'd1)));
      irdy_n_q     <= !((state_d == S_DATA) || (state_d == S_ABORT));
      oe_q         <= (state_d == S_ADDR) || (state_d == S_DATA) ||
                      (state_d == S_ABORT) || (state_d == S_TURN);
      busy_q       <= (state_d != S_IDLE);
      ack_q        <= ack_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign REQ        = req_q;
  assign FRAME_N    = frame_n_q;
  assign IRDY_N     = irdy_n_q;
  assign BUS_OE     = oe_q;
  assign busy       = busy_q;
  assign data_ack   = ack_q;
  assign xfer_count = xfer_q;
  assign done       = done_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed cycle-by-cycle bench for pci_initiator.
// Each vector holds the inputs for one clock and the outputs expected after
// that edge. The control outputs are packed as
// {REQ, FRAME_N, IRDY_N, BUS_OE, busy, data_ack, done, abort}.
module tb_pci_initiator;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [3:0] num;
    logic       gnt;
    logic       gframe;
    logic       girdy;
    logic       gtrdy;
    logic [7:0] exp_ctl;
    logic [3:0] exp_xfer;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] num_phases;
  logic       GNT;
  logic       GLOBAL_FRAME;
  logic       GLOBAL_IRDY;
  logic       GLOBAL_TRDY;
  logic       REQ;
  logic       FRAME_N;
  logic       IRDY_N;
  logic       BUS_OE;
  logic       busy;
  logic       data_ack;
  logic [3:0] xfer_count;
  logic       done;
  logic       abort;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  pci_initiator #(.MAX_WAIT(8), .LAT_TIMER(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_phases   (num_phases),
    .GNT          (GNT),
    .GLOBAL_FRAME (GLOBAL_FRAME),
    .GLOBAL_IRDY  (GLOBAL_IRDY),
    .GLOBAL_TRDY  (GLOBAL_TRDY),
    .REQ          (REQ),
    .FRAME_N      (FRAME_N),
    .IRDY_N       (IRDY_N),
    .BUS_OE       (BUS_OE),
    .busy         (busy),
    .data_ack     (data_ack),
    .xfer_count   (xfer_count),
    .done         (done),
    .abort        (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] n,
                              input logic g, input logic f, input logic i,
                              input logic t, input logic [7:0] c,
                              input logic [3:0] x);
    vec_t v;
    v.rst = r; v.start = s; v.num = n; v.gnt = g;
    v.gframe = f; v.girdy = i; v.gtrdy = t;
    v.exp_ctl = c; v.exp_xfer = x;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag, input int idx);
    logic [7:0] act;
    @(negedge clk);
    rst          = v.rst;
    start        = v.start;
    num_phases   = v.num;
    GNT          = v.gnt;
    GLOBAL_FRAME = v.gframe;
    GLOBAL_IRDY  = v.girdy;
    GLOBAL_TRDY  = v.gtrdy;
    @(posedge clk);
    #1;
    act = {REQ, FRAME_N, IRDY_N, BUS_OE, busy, data_ack, done, abort};
    n_vec++;
    if ((act !== v.exp_ctl) || (xfer_count !== v.exp_xfer)) begin
      n_err++;
      $display("FAIL %s[%0d]: got ctl=%b xfer=%0d, want ctl=%b xfer=%0d",
               tag, idx, act, xfer_count, v.exp_ctl, v.exp_xfer);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_phases = 4'd0;
    GNT = 1'b1; GLOBAL_FRAME = 1'b1; GLOBAL_IRDY = 1'b1; GLOBAL_TRDY = 1'b1;

    //           rst st  n  gnt fr ir tr   RFIO_BADA     xfer
    // reset, then a zero-wait single phase
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 8'b1110_0000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 8'b1110_0000, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1101_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1111_1100, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1110_0010, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 8'b1110_0000, 1));
    // four phases, two wait states before phase 3
    tbl.push_back(mk(1, 1, 4, 1, 1, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1001_1100, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1001_1100, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1101_1100, 3));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1111_1100, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1110_0010, 4));
    // granted but bus busy: wait for FRAME# and IRDY# both high
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1101_1100, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1111_1100, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1110_0010, 2));
    // start with zero phases is ignored and xfer_count holds
    tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 8'b1110_0000, 2));
    // reset during DATA of a 4-phase burst; start while busy ignored
    tbl.push_back(mk(1, 1, 4, 1, 1, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, 8'b1001_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1001_1100, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'b1110_0000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 8'b1110_0000, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 8'b0110_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1101_1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8'b1111_1100, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 8'b1110_0010, 1));

    foreach (tbl[i]) step(tbl[i], "vec", i);

    // master abort: TRDY# high on 8 consecutive DATA edges
    step(mk(1, 1, 2, 1, 1, 1, 1, 8'b0110_1000, 0), "abort_req", 0);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0), "abort_addr", 0);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 0), "abort_data", 0);
    for (int k = 1; k <= 7; k++)
      step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1001_1000, 0), "abort_wait", k);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1101_1000, 0), "abort_state", 8);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1111_1000, 0), "abort_turn", 0);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1110_0011, 0), "abort_done", 0);
    step(mk(1, 0, 0, 1, 1, 1, 1, 8'b1110_0000, 0), "abort_idle", 0);

    // latency-timer preemption: LAT_TIMER=4, 15 phases, GNT# withdrawn after ADDR
    step(mk(1, 1, 15, 1, 1, 1, 1, 8'b0110_1000, 0), "lat_req", 0);
    step(mk(1, 0, 0, 0, 1, 1, 1, 8'b1011_1000, 0), "lat_addr", 0);
    step(mk(1, 0, 0, 1, 1, 1, 0, 8'b1001_1000, 0), "lat_data", 0);
    for (int k = 1; k <= 3; k++)
      step(mk(1, 0, 0, 1, 1, 1, 0, 8'b1001_1100, 4'(k)), "lat_phase", k);
    step(mk(1, 0, 0, 1, 1, 1, 0, 8'b1101_1100, 4), "lat_preempt", 4);
    step(mk(1, 0, 0, 1, 1, 1, 0, 8'b1111_1100, 5), "lat_last", 5);
    step(mk(1, 0, 0, 1, 1, 1, 1, 8'b1110_0010, 5), "lat_done", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
